// File: rtl/checkpoint_seq_monitor.sv
// checkpoint_seq_monitor
//   Checks that a status word walks through an ordered table of expected
//   values. Each incoming word passes a stability filter first. The block
//   then advances one stage per matching value. It reports a pass, a
//   strict-order violation (an unexpected new value) or a per-stage timeout.
//
// Ports
//   axis_clk, axis_rst_n     clock, synchronous active-low reset
//   cfg_we/cfg_addr/cfg_wdata  expected-value table write (ignored while busy)
//   cfg_len/cfg_timeout/cfg_strict  run configuration, latched on start
//   start, abort             control pulses
//   chk_in                   observed status word
//   busy, done, pass, timeout_o, hit, stage, fail_val  status / result
module checkpoint_seq_monitor #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned TIMEOUT_W  = 24,
    parameter int unsigned STABLE_CYC = 2,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned LW = $clog2(DEPTH + 1)
) (
    input  logic                 axis_clk,
    input  logic                 axis_rst_n,
    input  logic                 cfg_we,
    input  logic [AW-1:0]        cfg_addr,
    input  logic [WIDTH-1:0]     cfg_wdata,
    input  logic [LW-1:0]        cfg_len,
    input  logic [TIMEOUT_W-1:0] cfg_timeout,
    input  logic                 cfg_strict,
    input  logic                 start,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     chk_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout_o,
    output logic                 hit,
    output logic [AW-1:0]        stage,
    output logic [WIDTH-1:0]     fail_val
);

    localparam int unsigned SW = $clog2(STABLE_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      tab_q [DEPTH];
    logic [WIDTH-1:0]      chk_q;
    logic [SW-1:0]         stab_q, stab_d;
    logic [LW-1:0]         len_q, len_d;
    logic [TIMEOUT_W-1:0]  to_q, to_d;
    logic                  strict_q, strict_d;
    logic [TIMEOUT_W-1:0]  timer_q, timer_d;
    logic [WIDTH-1:0]      last_q, last_d;
    logic [AW-1:0]         stage_q, stage_d;
    logic [WIDTH-1:0]      fail_q, fail_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic                  tmo_q, tmo_d;
    logic                  hit_q, hit_d;

    logic                  qual;
    logic                  match;
    logic                  last_stage;
    logic [TIMEOUT_W-1:0]  timer_inc;

    // Expected-value table; contents deliberately not reset.
    always_ff @(posedge axis_clk) begin
        if (cfg_we && (state_q != S_RUN) && (32'(cfg_addr) < DEPTH)) begin
            tab_q[cfg_addr] <= cfg_wdata;
        end
    end

    // Stability filter: stab_d counts repeat edges of the same value and
    // saturates, so a held value qualifies exactly once (STABLE_CYC-th edge).
    always_comb begin
        if (chk_in != chk_q) begin
            stab_d = '0;
        end else if (stab_q == SW'(STABLE_CYC)) begin
            stab_d = stab_q;
        end else begin
            stab_d = stab_q + 1'b1;
        end
        qual = (stab_d == SW'(STABLE_CYC - 1));
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        to_d       = to_q;
        strict_d   = strict_q;
        timer_d    = timer_q;
        last_d     = last_q;
        stage_d    = stage_q;
        fail_d     = fail_q;
        done_d     = done_q;
        pass_d     = pass_q;
        tmo_d      = tmo_q;
        hit_d      = 1'b0;
        match      = qual && (chk_in == tab_q[stage_q]);
        last_stage = (LW'(stage_q) == len_q - LW'(1));
        timer_inc  = timer_q + 1'b1;

        if (abort) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            pass_d  = 1'b0;
            tmo_d   = 1'b0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (match) begin
                        hit_d   = 1'b1;
                        timer_d = '0;
                        last_d  = chk_in;
                        if (last_stage) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            pass_d  = 1'b1;
                        end else begin
                            stage_d = stage_q + 1'b1;
                        end
                    end else begin
                        if (to_q != '0) begin
                            timer_d = timer_inc;
                        end
                        // Timeout outranks a strict-order failure on the same edge.
                        if ((to_q != '0) && (timer_inc == to_q)) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            tmo_d   = 1'b1;
                        end else if (qual && (chk_in != last_q)) begin
                            if (strict_q) begin
                                state_d = S_DONE;
                                done_d  = 1'b1;
                                fail_d  = chk_in;
                            end else begin
                                last_d = chk_in;
                            end
                        end
                    end
                end
                default: begin
                    if (start) begin
                        len_d    = cfg_len;
                        to_d     = cfg_timeout;
                        strict_d = cfg_strict;
                        stage_d  = '0;
                        timer_d  = '0;
                        last_d   = chk_q;
                        fail_d   = '0;
                        tmo_d    = 1'b0;
                        if (cfg_len == '0) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            pass_d  = 1'b1;
                        end else begin
                            state_d = S_RUN;
                            done_d  = 1'b0;
                            pass_d  = 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge axis_clk) begin
        if (!axis_rst_n) begin
            state_q  <= S_IDLE;
            chk_q    <= '0;
            stab_q   <= '0;
            len_q    <= '0;
            to_q     <= '0;
            strict_q <= 1'b0;
            timer_q  <= '0;
            last_q   <= '0;
            stage_q  <= '0;
            fail_q   <= '0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            tmo_q    <= 1'b0;
            hit_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            chk_q    <= chk_in;
            stab_q   <= stab_d;
            len_q    <= len_d;
            to_q     <= to_d;
            strict_q <= strict_d;
            timer_q  <= timer_d;
            last_q   <= last_d;
            stage_q  <= stage_d;
            fail_q   <= fail_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            tmo_q    <= tmo_d;
            hit_q    <= hit_d;
        end
    end

    assign busy      = (state_q == S_RUN);
    assign done      = done_q;
    assign pass      = pass_q;
    assign timeout_o = tmo_q;
    assign hit       = hit_q;
    assign stage     = stage_q;
    assign fail_val  = fail_q;

endmodule
